ram_load_unit: RTL and testbench
================================

Name: ram_load_unit

Overview:
- Load-side counterpart of the store-path lane formatter.
- Accepts a byte/word/long read request with a byte address and issues a single aligned read to the 32-bit big-endian RAM.
- Extracts the addressed lane from the returned long, right-justifies it and zero-extends it into a 32-bit result.
- Sits between the CPU memory stage and the RAM read port; one outstanding request at a time, valid/ready on both sides.

Parameters:
- ADDR_WIDTH, 16, byte-address width; RAM word address is ADDR_WIDTH-2 bits.
- RAM_LATENCY, 1, cycles from the ram_re cycle to valid ram_data_in; legal range 1..3.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request
- req_addr  input  ADDR_WIDTH  byte address
- req_type  input  data_type_t  RAM_LONG / RAM_WORD / RAM_BYTE
- resp_valid  output  1  result available
- resp_ready  input  1  consumer takes result
- resp_data  output  RAM_LONG_SIZE  extracted, extended value
- resp_err  output  1  misaligned request flag, qualified by resp_valid
- ram_re  output  1  RAM read enable, one-cycle pulse
- ram_addr  output  ADDR_WIDTH-2  RAM long address (req_addr[ADDR_WIDTH-1:2])
- ram_data_in  input  RAM_LONG_SIZE  RAM read data

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high on rst.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_data=0, ram_re=0, ram_addr=0, latency counter=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, register addr and type, check alignment, then leave IDLE.
  - Aligned: go to ISSUE.
  - Misaligned: go directly to RESP with resp_err=1 and resp_data=0; no RAM access.
- Alignment rules:
  - RAM_LONG needs addr[1:0]=0.
  - RAM_WORD needs addr[0]=0.
  - RAM_BYTE is always aligned.
  - Any other req_type encoding is treated as RAM_LONG.
- ISSUE: ram_re=1 for exactly one cycle; ram_addr = registered addr[ADDR_WIDTH-1:2]. ram_addr holds until RESP is left. Next state WAIT; counter loads RAM_LATENCY-1.
- WAIT: counter decrements each cycle. In the cycle where the counter is 0, capture the formatted ram_data_in into resp_data, then go to RESP.
- RESP: resp_valid=1. resp_data and resp_err are held stable until resp_ready=1. On that edge go to IDLE, resp_valid=0.
- Lane extraction is big-endian: byte offset 0 is bits[31:24].
  - RAM_LONG: data = ram_data_in.
  - RAM_WORD, addr[1]=0: data = {16'b0, ram_data_in[31:16]}.
  - RAM_WORD, addr[1]=1: data = {16'b0, ram_data_in[15:0]}.
  - RAM_BYTE, offset k = addr[1:0]: data = {24'b0, ram_data_in[31-8k -: 8]}.
- Latency with RAM_LATENCY=L: accept edge ends cycle 0; ram_re in cycle 1; capture at end of cycle 1+L; resp_valid from cycle 2+L. Throughput is one request per 3+L cycles minimum.
- req_ready=0 in every state except IDLE. There is no back-to-back acceptance in RESP, even when resp_ready=1.
- Changes on req_* while busy are ignored.
- Reset mid-operation: rst asserted in any state returns to IDLE on the next edge with all outputs at reset values. Any pending RAM data is discarded; a late ram_data_in is not captured.
- rst has priority over every handshake in the same cycle.

Optional Feature:
- Macro: RAM_LOAD_SIGN_EXT_EN.
- Defined: adds input port req_signed (1 bit, sampled at accept). When 1, RAM_WORD and RAM_BYTE results are sign-extended from bit 15 and bit 7 respectively. When 0, or for RAM_LONG, results are zero-extended.
- Undefined: the port is absent and all results are zero-extended exactly as in Behaviour.

Test Plan:
- Reset, then RAM long 0x11223344 at ram_addr 0x0004. Byte loads at req_addr 0x0010..0x0013 -> resp_data 0x00000011, 0x00000022, 0x00000033, 0x00000044; resp_err=0; ram_re pulses once per request with ram_addr=0x0004.
- Same RAM long, RAM_WORD at 0x0010 and 0x0012 -> 0x00001122 and 0x00003344. RAM_LONG at 0x0010 -> 0x11223344. With L=1, resp_valid asserted exactly 3 cycles after the accept edge.
- Misaligned requests: RAM_LONG at 0x0012 and RAM_WORD at 0x0011 -> resp_valid one cycle after accept, resp_err=1, resp_data=0, ram_re never asserted.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_data stable, req_ready=0 throughout. Release -> resp_valid drops next cycle and req_ready=1.
- Reset mid-WAIT with RAM_LATENCY=3: assert rst during the second WAIT cycle -> next cycle IDLE, resp_valid=0, req_ready=1. No response ever appears for the aborted request.
- With RAM_LOAD_SIGN_EXT_EN, RAM long 0x80F17F00, req_signed=1:
  - byte at offset 1 -> 0xFFFFFFF1
  - byte at offset 2 -> 0x0000007F
  - word at offset 0 -> 0xFFFF80F1
  - the same word load with req_signed=0 -> 0x000080F1

Source files
------------

// File: rtl/ram_load_unit.sv
// ram_load_unit: load-side lane extractor between the CPU memory stage and a
// 32-bit big-endian RAM read port. Accepts one byte/word/long read request at
// a time, issues a single aligned RAM read, then right-justifies the addressed
// lane and zero-extends it into a 32-bit result. Misaligned requests are
// answered immediately with resp_err=1 and no RAM access.
//
// Optional build macro: RAM_LOAD_SIGN_EXT_EN adds input req_signed (sampled at
// accept); when set, word/byte results are sign-extended instead.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   req_valid/ready   request handshake; req_addr byte address, req_type size
//   resp_valid/ready  response handshake; resp_data result, resp_err misalign
//   ram_re, ram_addr  one-cycle read strobe and long address to the RAM
//   ram_data_in       RAM read data, valid RAM_LATENCY cycles after ram_re

package ram_load_pkg;
  localparam int RAM_LONG_SIZE = 32;
  typedef enum logic [1:0] {
    RAM_LONG = 2'b00,
    RAM_WORD = 2'b01,
    RAM_BYTE = 2'b10
  } data_type_t;
endpackage

module ram_load_unit
  import ram_load_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int RAM_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  input  data_type_t               req_type,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [RAM_LONG_SIZE-1:0] resp_data,
  output logic                     resp_err,
  output logic                     ram_re,
  output logic [ADDR_WIDTH-3:0]    ram_addr,
  input  logic [RAM_LONG_SIZE-1:0] ram_data_in
`ifdef RAM_LOAD_SIGN_EXT_EN
  ,
  input  logic                     req_signed
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state;
  logic [1:0] off_q;
  data_type_t type_q;
  logic [1:0] cnt;
  logic       signed_q;

  // Unknown type encodings fall into the default arm and behave as RAM_LONG.
  function automatic logic misaligned(input data_type_t t, input logic [1:0] a);
    case (t)
      RAM_WORD: misaligned = a[0];
      RAM_BYTE: misaligned = 1'b0;
      default:  misaligned = a[1] | a[0];
    endcase
  endfunction

  // Big-endian lanes: byte offset 0 is bits [31:24].
  function automatic logic [RAM_LONG_SIZE-1:0] format_lane(
    input data_type_t t, input logic [1:0] off,
    input logic [RAM_LONG_SIZE-1:0] d, input logic sgn);
    logic [15:0] w;
    logic [7:0]  b;
    w = off[1] ? d[15:0] : d[31:16];
    case (off)
      2'd0:    b = d[31:24];
      2'd1:    b = d[23:16];
      2'd2:    b = d[15:8];
      default: b = d[7:0];
    endcase
    case (t)
      RAM_WORD: format_lane = {{16{sgn & w[15]}}, w};
      RAM_BYTE: format_lane = {{24{sgn & b[7]}}, b};
      default:  format_lane = d;
    endcase
  endfunction

`ifndef RAM_LOAD_SIGN_EXT_EN
  assign signed_q = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_data  <= '0;
      ram_re     <= 1'b0;
      ram_addr   <= '0;
      cnt        <= '0;
      off_q      <= '0;
      type_q     <= RAM_LONG;
`ifdef RAM_LOAD_SIGN_EXT_EN
      signed_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            off_q     <= req_addr[1:0];
            type_q    <= req_type;
`ifdef RAM_LOAD_SIGN_EXT_EN
            signed_q  <= req_signed;
`endif
            req_ready <= 1'b0;
            if (misaligned(req_type, req_addr[1:0])) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= '0;
              state      <= RESP;
            end else begin
              ram_addr <= req_addr[ADDR_WIDTH-1:2];
              ram_re   <= 1'b1;
              state    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          ram_re <= 1'b0;
          cnt    <= 2'(RAM_LATENCY - 1);
          state  <= WAIT;
        end
        WAIT: begin
          if (cnt == 2'd0) begin
            resp_data  <= format_lane(type_q, off_q, ram_data_in, signed_q);
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        RESP: begin
          // No new acceptance here; req_ready only rises once back in IDLE.
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_load_unit.sv
// Directed bench for ram_load_unit: one instance at RAM_LATENCY=1 and one at
// RAM_LATENCY=3, each fed by a small delayed-read RAM model that drives
// garbage outside the exact data-valid cycle.
module tb_ram_load_unit;
  import ram_load_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] req_addr = '0;
  data_type_t  req_type = RAM_LONG;
`ifdef RAM_LOAD_SIGN_EXT_EN
  logic        req_signed = 1'b0;
`endif

  logic        req_valid = 1'b0, resp_ready = 1'b0;
  logic        req_ready, resp_valid, resp_err, ram_re;
  logic [31:0] resp_data, ram_data;
  logic [13:0] ram_addr;

  logic        req_valid3 = 1'b0, resp_ready3 = 1'b0;
  logic        req_ready3, resp_valid3, resp_err3, ram_re3;
  logic [31:0] resp_data3, ram_data3;
  logic [13:0] ram_addr3;

  logic [31:0] ram_word = 32'h1122_3344;
  int          n_cmp = 0, n_err = 0;
  int          re_cnt = 0;
  logic [13:0] last_ra = '0;

  always #5 clk = ~clk;

  ram_load_unit #(.ADDR_WIDTH(16), .RAM_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_type(req_type), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .ram_re(ram_re), .ram_addr(ram_addr), .ram_data_in(ram_data)
`ifdef RAM_LOAD_SIGN_EXT_EN
    , .req_signed(req_signed)
`endif
  );

  ram_load_unit #(.ADDR_WIDTH(16), .RAM_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_addr(req_addr), .req_type(req_type), .resp_valid(resp_valid3),
    .resp_ready(resp_ready3), .resp_data(resp_data3), .resp_err(resp_err3),
    .ram_re(ram_re3), .ram_addr(ram_addr3), .ram_data_in(ram_data3)
`ifdef RAM_LOAD_SIGN_EXT_EN
    , .req_signed(req_signed)
`endif
  );

  // RAM model: only long address 0x0004 holds ram_word.
  function automatic logic [31:0] mem_rd(input logic [13:0] a);
    return (a == 14'h0004) ? ram_word : 32'hBAD0_0000;
  endfunction

  logic [3:1]  pv1 = '0, pv3 = '0;
  logic [13:0] pa1 [1:3];
  logic [13:0] pa3 [1:3];

  always @(posedge clk) begin
    pv1[1] <= ram_re;  pa1[1] <= ram_addr;
    pv3[1] <= ram_re3; pa3[1] <= ram_addr3;
    for (int i = 2; i <= 3; i++) begin
      pv1[i] <= pv1[i-1]; pa1[i] <= pa1[i-1];
      pv3[i] <= pv3[i-1]; pa3[i] <= pa3[i-1];
    end
    if (ram_re) begin
      re_cnt  = re_cnt + 1;
      last_ra = ram_addr;
    end
  end

  assign ram_data  = pv1[1] ? mem_rd(pa1[1]) : 32'hDEAD_BEEF;
  assign ram_data3 = pv3[3] ? mem_rd(pa3[3]) : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request to the L=1 instance; called and returns at a negedge.
  // lat = number of clock edges after the accept edge until resp_valid is seen.
  task automatic do_load(input data_type_t t, input logic [15:0] a, input logic sgn,
                         input int hold, output logic [31:0] d, output logic e,
                         output int lat, output int nre);
    int re0;
    re0       = re_cnt;
    req_valid = 1'b1;
    req_type  = t;
    req_addr  = a;
`ifdef RAM_LOAD_SIGN_EXT_EN
    req_signed = sgn;
`else
    if (sgn) req_addr = a;
`endif
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    d = resp_data;
    e = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", {31'b0, resp_valid}, 32'd1);
      check("hold_data", resp_data, d);
      check("hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    nre = re_cnt - re0;
    check("release_valid", {31'b0, resp_valid}, 32'd0);
    check("release_req_ready", {31'b0, req_ready}, 32'd1);
  endtask

  logic [31:0] d;
  logic        e;
  int          lat, nre, seen;
  logic [31:0] byte_exp [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_ram_re", {31'b0, ram_re}, 32'd0);
    check("rst_ram_addr", {18'b0, ram_addr}, 32'h0);

    for (int k = 0; k < 4; k++) begin
      do_load(RAM_BYTE, 16'h0010 + 16'(k), 1'b0, 0, d, e, lat, nre);
      check("byte_data", d, byte_exp[k]);
      check("byte_err", {31'b0, e}, 32'd0);
      check("byte_re_count", nre, 32'd1);
      check("byte_ram_addr", {18'b0, last_ra}, 32'h4);
    end

    do_load(RAM_WORD, 16'h0010, 1'b0, 0, d, e, lat, nre);
    check("word0_data", d, 32'h0000_1122);
    do_load(RAM_WORD, 16'h0012, 1'b0, 0, d, e, lat, nre);
    check("word2_data", d, 32'h0000_3344);
    do_load(RAM_LONG, 16'h0010, 1'b0, 0, d, e, lat, nre);
    check("long_data", d, 32'h1122_3344);
    check("long_latency", lat, 32'd3);
    check("long_err", {31'b0, e}, 32'd0);
    do_load(data_type_t'(2'b11), 16'h0010, 1'b0, 0, d, e, lat, nre);
    check("enc3_data", d, 32'h1122_3344);

    do_load(RAM_LONG, 16'h0012, 1'b0, 0, d, e, lat, nre);
    check("mis_long_err", {31'b0, e}, 32'd1);
    check("mis_long_data", d, 32'h0);
    check("mis_long_latency", lat, 32'd1);
    check("mis_long_re", nre, 32'd0);
    do_load(RAM_WORD, 16'h0011, 1'b0, 0, d, e, lat, nre);
    check("mis_word_err", {31'b0, e}, 32'd1);
    check("mis_word_data", d, 32'h0);
    check("mis_word_latency", lat, 32'd1);
    check("mis_word_re", nre, 32'd0);
    do_load(data_type_t'(2'b11), 16'h0012, 1'b0, 0, d, e, lat, nre);
    check("mis_enc3_err", {31'b0, e}, 32'd1);

    do_load(RAM_LONG, 16'h0010, 1'b0, 5, d, e, lat, nre);
    check("bp_data", d, 32'h1122_3344);

    // L=3 instance: normal load, then reset in the second WAIT cycle.
    req_type = RAM_BYTE; req_addr = 16'h0011; req_valid3 = 1'b1;
    @(negedge clk);
    req_valid3 = 1'b0;
    lat = 1;
    while (!resp_valid3 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("l3_latency", lat, 32'd5);
    check("l3_data", resp_data3, 32'h22);
    resp_ready3 = 1'b1;
    @(negedge clk);
    resp_ready3 = 1'b0;

    req_type = RAM_LONG; req_addr = 16'h0010; req_valid3 = 1'b1;
    @(negedge clk);                    // cycle 1 (ISSUE)
    req_valid3 = 1'b0;
    @(negedge clk);                    // cycle 2 (first WAIT)
    @(negedge clk);                    // cycle 3 (second WAIT)
    check("l3_busy_ready", {31'b0, req_ready3}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_valid", {31'b0, resp_valid3}, 32'd0);
    check("abort_req_ready", {31'b0, req_ready3}, 32'd1);
    check("abort_data", resp_data3, 32'h0);
    check("abort_ram_re", {31'b0, ram_re3}, 32'd0);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (resp_valid3) seen++;
    end
    check("abort_no_resp", seen, 32'd0);

`ifdef RAM_LOAD_SIGN_EXT_EN
    ram_word = 32'h80F1_7F00;
    do_load(RAM_BYTE, 16'h0011, 1'b1, 0, d, e, lat, nre);
    check("sx_byte1", d, 32'hFFFF_FFF1);
    do_load(RAM_BYTE, 16'h0012, 1'b1, 0, d, e, lat, nre);
    check("sx_byte2", d, 32'h0000_007F);
    do_load(RAM_WORD, 16'h0010, 1'b1, 0, d, e, lat, nre);
    check("sx_word0", d, 32'hFFFF_80F1);
    do_load(RAM_WORD, 16'h0010, 1'b0, 0, d, e, lat, nre);
    check("zx_word0", d, 32'h0000_80F1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
